uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVS_DIV, default 54, clk cycles per 16x oversample tick (100 MHz / (115200*16)).
REQ-002 Parameter: DATA_BITS, default 8, data bits per frame; only 8 is required.
REQ-003 Port: clk  input  1  system clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-006 Port: rx_data  output  8  last correctly framed byte, held until the next good byte; drives the CPU top's rx_data.
REQ-007 Port: rx_valid  output  1  one-cycle pulse, rx_data updated this cycle.
REQ-008 Port: frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; rx_s denotes its output.
REQ-011 The baud generator SHALL assert tick for one clk every OVS_DIV cycles, and SHALL restart its count on a start-edge detect.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, RECOVER.
REQ-013 IDLE: rx_s==0 SHALL move to START and clear the 4-bit sample counter and the 3-bit bit counter.
REQ-014 START: on the 8th tick (mid start bit), rx_s==1 SHALL return to IDLE with no output pulse (glitch reject); rx_s==0 SHALL clear the sample counter and move to DATA.
REQ-015 DATA: every 16th tick SHALL sample rx_s into the shift register, LSB first (right shift, new bit at MSB); after the 8th bit it SHALL move to STOP.
REQ-016 STOP: on the 16th tick, rx_s==1 SHALL load rx_data from the shift register, pulse rx_valid the next cycle, and go to IDLE.
REQ-017 STOP: on the 16th tick, rx_s==0 SHALL pulse frame_err, leave rx_data unchanged, and go to RECOVER.
REQ-018 RECOVER SHALL wait for rx_s==1 before going to IDLE, so a held-low line (break) yields exactly one frame_err.
REQ-019 rx_valid and frame_err SHALL never be high in the same cycle, and each pulse SHALL last exactly one cycle.
REQ-020 Latency: rx_valid SHALL rise 2 + 16*9.5*OVS_DIV cycles (+/- OVS_DIV) after the rxd falling edge.
REQ-021 Back-to-back frames (start bit directly after stop bit) SHALL be received without loss; IDLE is re-entered before the next start edge arrives.
REQ-022 Counters SHALL saturate nowhere: the sample counter wraps 15->0, the bit counter is compared against DATA_BITS-1.

Reset
REQ-023 reset SHALL asynchronously force: state=IDLE, synchronizer=1, shift=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, all counters=0.
REQ-024 reset asserted mid-frame SHALL discard the partial byte, produce no pulse, and receive the next full frame normally after release.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum and the default OVS_DIV and DATA_BITS constants.
REQ-026 The tick generator SHALL be sub-module baud_gen (ports: clk, reset, restart, tick); all other logic stays in uart_rx.

Verification (OVS_DIV=4, i.e. 64 clk per bit)
REQ-027 Send 0xA5 with a valid stop bit -> rx_data=0xA5, exactly one rx_valid pulse about 610 cycles after the start edge, and frame_err stays 0.
REQ-028 Drive rxd low for 20 cycles, then high -> no rx_valid or frame_err, busy returns to 0, and rx_data remains 0x00.
REQ-029 Send 0x3C with the stop bit low, then hold rxd low for 2000 cycles -> one frame_err pulse, rx_data unchanged, state RECOVER until rxd goes high.
REQ-030 Send 0x00 then 0xFF back-to-back -> two rx_valid pulses, with rx_data 0x00 then 0xFF.
REQ-031 Assert reset during bit 4 of 0x55, release it, then send 0x81 -> no pulse for the aborted frame, and rx_data=0x81 with one rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// UART receiver shared definitions: FSM state
// encoding and default parameter values.
package uart_pkg;

  // 100 MHz / (115200 baud * 16x oversampling)
  localparam int OVS_DIV_DEF   = 54;
  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

endpackage

// File: rtl/uart_rx_baud_gen.sv
// 16x oversample tick generator for uart_rx.
// Ports:
//   clk     in   system clock
//   reset   in   async active-high reset
//   restart in   realign count to a start edge
//   tick    out  one-cycle pulse every OVS_DIV clks
module baud_gen
  import uart_pkg::*;
#(
  parameter int OVS_DIV = OVS_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW =
    (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(OVS_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A restart cycle never ticks, so the first
  // tick after a start edge is a full period out.
  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit
// sampling, glitch reject and break recovery.
// Ports:
//   clk       in   system clock
//   reset     in   async active-high reset
//   rxd       in   async serial line, idle high
//   rx_data   out  last good byte, held
//   rx_valid  out  1-clk pulse, rx_data updated
//   frame_err out  1-clk pulse, stop bit low
//   busy      out  receiver not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS_DIV   = OVS_DIV_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  logic                 sync1;
  logic                 rx_s;
  logic                 tick;
  logic                 restart;

  state_t               state;
  state_t               state_nxt;

  logic [3:0]           sample_cnt;
  logic [3:0]           sample_nxt;
  logic [2:0]           bit_cnt;
  logic [2:0]           bit_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;

  // Two-flop synchronizer, idles at the line's
  // mark level so reset never fakes a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
    end
  end

  baud_gen #(
    .OVS_DIV (OVS_DIV)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sample_nxt = sample_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    data_nxt   = rx_data;
    valid_nxt  = 1'b0;
    ferr_nxt   = 1'b0;
    restart    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt  = START;
          sample_nxt = '0;
          bit_nxt    = '0;
          restart    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (sample_cnt == 4'd7) begin
            // Mid start bit: a high line here
            // was only a glitch.
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              sample_nxt = '0;
              state_nxt  = DATA;
            end
          end else begin
            sample_nxt = sample_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          // Wraps 15->0, realigning to the
          // centre of the next bit.
          sample_nxt = sample_cnt + 4'd1;
          if (sample_cnt == 4'd15) begin
            shift_nxt =
              {rx_s, shift[DATA_BITS-1:1]};
            bit_nxt = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          sample_nxt = sample_cnt + 4'd1;
          if (sample_cnt == 4'd15) begin
            // Leaving at mid stop bit gives
            // half a bit of slack before a
            // back-to-back start edge.
            if (rx_s) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = RECOVER;
            end
          end
        end
      end
      RECOVER: begin
        // Hold off until the line returns to
        // mark so a break reports only once.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sample_cnt <= sample_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      rx_data    <= data_nxt;
      rx_valid   <= valid_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
